// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: synchronises the scan strobe and columns, walks
// the rows once per strobe, and debounces whole frames into one code per press.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_div,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic        div_s1_q, div_s1_d;
  logic        div_s2_q, div_s2_d;
  logic        div_s3_q, div_s3_d;
  logic        tick_q, tick_d;
  logic [3:0]  col_s1_q, col_s1_d;
  logic [3:0]  col_s2_q, col_s2_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_out_q, row_out_d;
  logic [15:0] frame_q, frame_d;
  logic        frame_done_q, frame_done_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_held_q, key_held_d;

  logic [4:0]  ones_s;
  logic [3:0]  idx_s;
  logic        none_s;
  logic        one_s;
  logic [3:0]  cnt_inc_s;
  logic        accept_s;
  logic        release_s;

  // State register: every flop in the block.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_s1_q     <= 1'b0;
      div_s2_q     <= 1'b0;
      div_s3_q     <= 1'b0;
      tick_q       <= 1'b0;
      col_s1_q     <= 4'b0000;
      col_s2_q     <= 4'b0000;
      row_idx_q    <= 2'd0;
      row_out_q    <= 4'b1110;
      frame_q      <= 16'h0000;
      frame_done_q <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cand_q       <= 4'd0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 4'd0;
      key_held_q   <= 1'b0;
    end else begin
      div_s1_q     <= div_s1_d;
      div_s2_q     <= div_s2_d;
      div_s3_q     <= div_s3_d;
      tick_q       <= tick_d;
      col_s1_q     <= col_s1_d;
      col_s2_q     <= col_s2_d;
      row_idx_q    <= row_idx_d;
      row_out_q    <= row_out_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
    end
  end

  // Synchronisers, strobe edge detect and row walk; tick is registered so it
  // lands three cycles after the strobe edge at the pin.
  always_comb begin
    div_s1_d     = clk_div;
    div_s2_d     = div_s1_q;
    div_s3_d     = div_s2_q;
    tick_d       = div_s2_q & ~div_s3_q;
    col_s1_d     = col_in;
    col_s2_d     = col_s1_q;
    row_idx_d    = row_idx_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    if (tick_q) begin
      frame_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;
      row_idx_d    = row_idx_q + 2'd1;
      frame_done_d = (row_idx_q == 2'd3);
    end else begin
      frame_done_d = 1'b0;
    end
    row_out_d = ~(4'b0001 << row_idx_d);
  end

  // Frame classification: count of pressed keys and index of the last one found.
  always_comb begin
    ones_s = 5'd0;
    idx_s  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        ones_s = ones_s + 5'd1;
        idx_s  = 4'(i);
      end else begin
        ones_s = ones_s;
      end
    end
    none_s    = (ones_s == 5'd0);
    one_s     = (ones_s == 5'd1);
    cnt_inc_s = (cnt_q >= DF) ? DF : (cnt_q + 4'd1);
  end

  // Next-state: press and release debouncing, advanced once per completed frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept_s  = 1'b0;
    release_s = 1'b0;
    if (frame_done_q) begin
      case (state_q)
        IDLE: begin
          if (one_s) begin
            cand_d = idx_s;
            if (DF <= 4'd1) begin
              accept_s = 1'b1;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DEBOUNCE: begin
          if (one_s && (idx_s == cand_q)) begin
            if (cnt_inc_s >= DF) begin
              accept_s = 1'b1;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else if (one_s) begin
            cand_d = idx_s;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HELD: begin
          if (none_s) begin
            if (DF <= 4'd1) begin
              release_s = 1'b1;
            end else begin
              cnt_d   = 4'd1;
              state_d = RELEASE;
            end
          end else begin
            state_d = HELD;
          end
        end
        RELEASE: begin
          if (none_s) begin
            if (cnt_inc_s >= DF) begin
              release_s = 1'b1;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (accept_s) begin
      state_d = HELD;
      cnt_d   = 4'd0;
    end else if (release_s) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Outputs: registered pulse, latched code and held flag.
  always_comb begin
    key_valid_d = accept_s;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    if (accept_s) begin
      key_code_d = cand_d;
      key_held_d = 1'b1;
    end else if (release_s) begin
      key_held_d = 1'b0;
    end else begin
      key_held_d = key_held_q;
    end
  end

  assign row_out   = row_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule
